a25_wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the write-back load path and execute-stage ALU results.

---
 rtl/a25_wb_pkg.sv | 23 ++
 rtl/a25_wb_exq.sv | 60 ++++++
 rtl/a25_wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_a25_wb_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/a25_wb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package a25_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_TAG_W  = 11;
  localparam int WB_RIDX_W = 5;
  localparam int WB_DEPTH  = 4;

  localparam logic SRC_EXEC = 1'b0;
  localparam logic SRC_LOAD = 1'b1;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_TAG_W-1:0]  tag;
  } wb_req_t;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PENDING,
    Q_FULL
  } q_state_t;

endpackage

// File: rtl/a25_wb_exq.sv
// In-order execute write queue with per-entry valid bits and a parallel register-index squash port.
// Push/pop update count one cycle later; the caller must never push when full or pop when empty.
module a25_wb_exq
  import a25_wb_pkg::*;
#(
  parameter type req_t  = wb_req_t,
  parameter int  RIDX_W = WB_RIDX_W,
  parameter int  DEPTH  = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_t                     push_req,
  input  logic                     pop,
  output req_t                     head_req,
  output logic                     head_vld,
  input  logic                     squash,
  input  logic [RIDX_W-1:0]        squash_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t              mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Squash is applied first so an entry pushed this cycle (younger than the load) keeps its valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].tag[RIDX_W-1:0] == squash_idx) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_req = mem[rd_ptr];
  assign head_vld = vld[rd_ptr];

endmodule

// File: rtl/a25_wb_port_arbiter.sv
// Register-file write-port arbiter: loads win, execute writes bypass or queue in order; 1-cycle registered output.
// Execute is valid/ready back-pressured on queue full or drain; loads are never stalled. Optional stats: A25_WB_ARB_STATS_EN.
module a25_wb_port_arbiter
  import a25_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int TAG_W  = WB_TAG_W,
  parameter int RIDX_W = WB_RIDX_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ld_valid,
  input  logic [DATA_W-1:0]       i_ld_data,
  input  logic [TAG_W-1:0]        i_ld_tag,
  input  logic                    i_ex_valid,
  input  logic [DATA_W-1:0]       i_ex_data,
  input  logic [TAG_W-1:0]        i_ex_tag,
  output logic                    o_ex_ready,
  input  logic                    i_drain_req,
  output logic                    o_drain_done,
  output logic                    o_rf_wen,
  output logic [DATA_W-1:0]       o_rf_wdata,
  output logic [TAG_W-1:0]        o_rf_wtag,
  output logic                    o_rf_src,
  output logic [$clog2(DEPTH):0]  o_q_count
`ifdef A25_WB_ARB_STATS_EN
  ,
  output logic [15:0]             o_stat_collide,
  output logic [15:0]             o_stat_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t     ld_req, ex_req, head_req, sel_req;
  logic     head_vld, ex_acc, push, pop, bypass, sel_wen, sel_src;
  q_state_t q_state;

  assign ld_req = {i_ld_data, i_ld_tag};
  assign ex_req = {i_ex_data, i_ex_tag};

  always_comb begin
    q_state = Q_PENDING;
    if (o_q_count == '0)                q_state = Q_EMPTY;
    else if (o_q_count == CNT_W'(DEPTH)) q_state = Q_FULL;
  end

  // Ready looks only at the registered count: a pop in this cycle does not free a slot early.
  assign o_ex_ready = i_rst_n && !i_drain_req && (q_state != Q_FULL);
  assign ex_acc     = i_ex_valid && o_ex_ready;

  always_comb begin
    sel_wen = 1'b0;
    sel_src = SRC_EXEC;
    sel_req = ex_req;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (i_ld_valid) begin
      sel_wen = 1'b1;
      sel_src = SRC_LOAD;
      sel_req = ld_req;
    end else if (q_state != Q_EMPTY) begin
      pop     = 1'b1;
      sel_wen = head_vld;
      sel_req = head_req;
    end else if (ex_acc) begin
      bypass  = 1'b1;
      sel_wen = 1'b1;
    end
  end

  assign push = ex_acc && !bypass;

  a25_wb_exq #(
    .req_t  (req_t),
    .RIDX_W (RIDX_W),
    .DEPTH  (DEPTH)
  ) u_exq (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .push       (push),
    .push_req   (ex_req),
    .pop        (pop),
    .head_req   (head_req),
    .head_vld   (head_vld),
    .squash     (i_ld_valid),
    .squash_idx (i_ld_tag[RIDX_W-1:0]),
    .count      (o_q_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_wen     <= 1'b0;
      o_rf_wdata   <= '0;
      o_rf_wtag    <= '0;
      o_rf_src     <= 1'b0;
      o_drain_done <= 1'b0;
    end else begin
      o_rf_wen     <= sel_wen;
      o_rf_wdata   <= sel_req.data;
      o_rf_wtag    <= sel_req.tag;
      o_rf_src     <= sel_src;
      // Done only after the last queued execute write has actually reached the register file.
      o_drain_done <= i_drain_req && (q_state == Q_EMPTY) && !(o_rf_wen && o_rf_src == SRC_EXEC);
    end
  end

`ifdef A25_WB_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stat_collide <= '0;
      o_stat_stall   <= '0;
    end else begin
      if (i_ld_valid && i_ex_valid && o_stat_collide != 16'hFFFF) o_stat_collide <= o_stat_collide + 16'd1;
      if (i_ex_valid && !o_ex_ready && o_stat_stall != 16'hFFFF)  o_stat_stall   <= o_stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_a25_wb_port_arbiter.sv
// Directed bench for a25_wb_port_arbiter with load/execute scoreboards checked by a write monitor.
module tb_a25_wb_port_arbiter;
  import a25_wb_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n, i_ld_valid, i_ex_valid, i_drain_req;
  logic [31:0] i_ld_data, i_ex_data;
  logic [10:0] i_ld_tag, i_ex_tag;
  logic        o_ex_ready, o_drain_done, o_rf_wen, o_rf_src;
  logic [31:0] o_rf_wdata;
  logic [10:0] o_rf_wtag;
  logic [2:0]  o_q_count;
`ifdef A25_WB_ARB_STATS_EN
  logic [15:0] o_stat_collide, o_stat_stall;
`endif

  always #5 clk = ~clk;

  a25_wb_port_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_ld_valid   (i_ld_valid),
    .i_ld_data    (i_ld_data),
    .i_ld_tag     (i_ld_tag),
    .i_ex_valid   (i_ex_valid),
    .i_ex_data    (i_ex_data),
    .i_ex_tag     (i_ex_tag),
    .o_ex_ready   (o_ex_ready),
    .i_drain_req  (i_drain_req),
    .o_drain_done (o_drain_done),
    .o_rf_wen     (o_rf_wen),
    .o_rf_wdata   (o_rf_wdata),
    .o_rf_wtag    (o_rf_wtag),
    .o_rf_src     (o_rf_src),
    .o_q_count    (o_q_count)
`ifdef A25_WB_ARB_STATS_EN
    ,
    .o_stat_collide (o_stat_collide),
    .o_stat_stall   (o_stat_stall)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic [10:0] t;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t ld_q[$];
  exp_t ex_q[$];
  exp_t e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every register-file write is matched against the oldest expected write of its source.
  always @(negedge clk) begin
    if (o_rf_wen === 1'b1) begin
      if (o_rf_src === 1'b1) begin
        chk("ld_sb_nonempty", 64'(ld_q.size() > 0), 64'd1);
        if (ld_q.size() > 0) begin
          e = ld_q.pop_front();
          chk("ld_wdata", 64'(o_rf_wdata), 64'(e.d));
          chk("ld_wtag", 64'(o_rf_wtag), 64'(e.t));
        end
      end else begin
        chk("ex_sb_nonempty", 64'(ex_q.size() > 0), 64'd1);
        if (ex_q.size() > 0) begin
          e = ex_q.pop_front();
          chk("ex_wdata", 64'(o_rf_wdata), 64'(e.d));
          chk("ex_wtag", 64'(o_rf_wtag), 64'(e.t));
        end
      end
    end
  end

  // One clock of stimulus; keep=0 marks an execute write that is expected to be squashed or discarded.
  task automatic cyc(input logic lv, input logic [10:0] lt, input logic ev, input logic [10:0] et,
                     input logic keep);
    i_ld_valid = lv;
    i_ld_tag   = lt;
    i_ld_data  = 32'hA500_0000 | 32'(lt);
    i_ex_valid = ev;
    i_ex_tag   = et;
    i_ex_data  = 32'hE700_0000 | 32'(et);
    #2;
    if (lv) ld_q.push_back({i_ld_data, lt});
    if (ev && o_ex_ready && keep) ex_q.push_back({i_ex_data, et});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic chk_wr(input string name, input logic wen, input logic src, input logic [10:0] tag,
                        input logic [2:0] cnt);
    chk({name, "_wen"}, 64'(o_rf_wen), 64'(wen));
    if (wen) begin
      chk({name, "_src"}, 64'(o_rf_src), 64'(src));
      chk({name, "_tag"}, 64'(o_rf_wtag), 64'(tag));
    end
    chk({name, "_cnt"}, 64'(o_q_count), 64'(cnt));
  endtask

  initial begin
    i_rst_n = 1'b0; i_drain_req = 1'b0;
    i_ld_valid = 1'b0; i_ld_data = '0; i_ld_tag = '0;
    i_ex_valid = 1'b0; i_ex_data = '0; i_ex_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 64'(o_rf_wen), 64'd0);
    chk("rst_wdata", 64'(o_rf_wdata), 64'd0);
    chk("rst_wtag", 64'(o_rf_wtag), 64'd0);
    chk("rst_src", 64'(o_rf_src), 64'd0);
    chk("rst_cnt", 64'(o_q_count), 64'd0);
    chk("rst_done", 64'(o_drain_done), 64'd0);
    chk("rst_ready", 64'(o_ex_ready), 64'd0);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(o_ex_ready), 64'd1);

    // Execute only: every write bypasses the empty queue.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 11'd0, 1'b1, 11'(i), 1'b1);
      chk_wr("exonly", 1'b1, 1'b0, 11'(i), 3'd0);
    end
    idle();
    chk_wr("exonly_idle", 1'b0, 1'b0, 11'd0, 3'd0);

    // Collision: load first, execute one cycle later.
    cyc(1'b1, 11'd3, 1'b1, 11'd5, 1'b1);
    chk_wr("coll_ld", 1'b1, 1'b1, 11'd3, 3'd1);
    idle();
    chk_wr("coll_ex", 1'b1, 1'b0, 11'd5, 3'd0);

    // Backpressure: five loads against continuous execute traffic.
    for (int i = 0; i < 5; i++) cyc(1'b1, 11'(10 + i), 1'b1, 11'(20 + i), 1'b1);
    chk("bp_cnt_full", 64'(o_q_count), 64'd4);
    chk("bp_ready", 64'(o_ex_ready), 64'd0);
    for (int i = 0; i < 4; i++) idle();
    chk_wr("bp_drained", 1'b1, 1'b0, 11'd23, 3'd0);
    idle();

    // Squash: queued execute tag 7 is superseded by a later load to the same register.
    cyc(1'b1, 11'd1, 1'b1, 11'd7, 1'b0);
    chk_wr("sq_push", 1'b1, 1'b1, 11'd1, 3'd1);
    cyc(1'b1, 11'd7, 1'b0, 11'd0, 1'b0);
    chk_wr("sq_ld", 1'b1, 1'b1, 11'd7, 3'd1);
    idle();
    chk_wr("sq_pop", 1'b0, 1'b0, 11'd0, 3'd0);
    cyc(1'b1, 11'd7, 1'b1, 11'd7, 1'b1);
    chk_wr("sq_same_ld", 1'b1, 1'b1, 11'd7, 3'd1);
    idle();
    chk_wr("sq_same_ex", 1'b1, 1'b0, 11'd7, 3'd0);

    // Drain with three queued entries.
    cyc(1'b1, 11'd2, 1'b1, 11'd8, 1'b1);
    cyc(1'b1, 11'd3, 1'b1, 11'd9, 1'b1);
    cyc(1'b1, 11'd4, 1'b1, 11'd10, 1'b1);
    chk("dr_cnt", 64'(o_q_count), 64'd3);
    i_drain_req = 1'b1;
    #1;
    chk("dr_ready", 64'(o_ex_ready), 64'd0);
    cyc(1'b0, 11'd0, 1'b1, 11'd30, 1'b1);
    chk_wr("dr_w1", 1'b1, 1'b0, 11'd8, 3'd2);
    idle();
    chk_wr("dr_w2", 1'b1, 1'b0, 11'd9, 3'd1);
    idle();
    chk_wr("dr_w3", 1'b1, 1'b0, 11'd10, 3'd0);
    chk("dr_done_w3", 64'(o_drain_done), 64'd0);
    idle();
    chk("dr_done_retire", 64'(o_drain_done), 64'd0);
    idle();
    chk("dr_done", 64'(o_drain_done), 64'd1);
    i_drain_req = 1'b0;
    idle();
    chk("dr_done_drop", 64'(o_drain_done), 64'd0);

    // Reset mid-drain discards the remaining queued entry.
    cyc(1'b1, 11'd5, 1'b1, 11'd11, 1'b1);
    cyc(1'b1, 11'd6, 1'b1, 11'd12, 1'b0);
    i_drain_req = 1'b1;
    idle();
    chk_wr("rd_w1", 1'b1, 1'b0, 11'd11, 3'd1);
    i_rst_n = 1'b0;
    idle();
    chk("rd_wen", 64'(o_rf_wen), 64'd0);
    chk("rd_wdata", 64'(o_rf_wdata), 64'd0);
    chk("rd_cnt", 64'(o_q_count), 64'd0);
    chk("rd_done", 64'(o_drain_done), 64'd0);
    chk("rd_ready", 64'(o_ex_ready), 64'd0);
    i_rst_n = 1'b1;
    i_drain_req = 1'b0;
    idle();
    chk_wr("rd_after1", 1'b0, 1'b0, 11'd0, 3'd0);
    idle();
    chk_wr("rd_after2", 1'b0, 1'b0, 11'd0, 3'd0);

`ifdef A25_WB_ARB_STATS_EN
    for (int i = 0; i < 10; i++) cyc(1'b1, 11'(8'h40 + i), 1'b1, 11'(8'h10 + i), 1'b1);
    chk("stat_collide", 64'(o_stat_collide), 64'd10);
    chk("stat_stall", 64'(o_stat_stall), 64'd6);
    for (int i = 0; i < 6; i++) idle();
    chk("stat_cnt", 64'(o_q_count), 64'd0);
`endif

    idle();
    chk("ld_sb_empty", 64'(ld_q.size()), 64'd0);
    chk("ex_sb_empty", 64'(ex_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
